fifo_flex: RTL and testbench

- Parametrised synchronous FIFO. It is the next generation of the team's basic fifo.
- Generalised in data width and depth. Exact full/empty at 2**addr_width entries.
- Selectable request mode: level, or synchronised falling-edge strobe.
- Selectable read mode: registered, or first-word-fall-through.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow flags and a synchronous clear.
- Sits between producer and consumer logic in the same clock domain. Edge mode serves requests from slow or asynchronous sources.

---
 rtl/fifo_flex.sv | 131 +++++++++++++
 tb/tb_fifo_flex.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with level or falling-edge requests, registered or
// first-word-fall-through read data, occupancy count, threshold flags and sticky error flags.
module fifo_flex #(
    parameter int data_width  = 8,
    parameter int adder_width = 4,
    parameter bit edge_mode   = 1'b0,
    parameter bit fwft        = 1'b0,
    parameter int af_thresh   = 2**adder_width - 2,
    parameter int ae_thresh   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wrt,
    input  logic                   rd,
    input  logic [data_width-1:0]  din,
    output logic [data_width-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [adder_width:0]   count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int depth = 2**adder_width;
    localparam logic [adder_width:0] depth_lvl = (adder_width+1)'(depth);
    localparam logic [adder_width:0] af_lvl    = (adder_width+1)'(af_thresh);
    localparam logic [adder_width:0] ae_lvl    = (adder_width+1)'(ae_thresh);

    logic [data_width-1:0]  mem [depth];
    logic [adder_width-1:0] wr_ptr;
    logic [adder_width-1:0] rd_ptr;
    logic                   wr_req;
    logic                   rd_req;
    logic                   wr_acc;
    logic                   rd_acc;

    generate
        if (edge_mode) begin : g_edge
            logic wr_s1, wr_s2, rd_s1, rd_s2;

            // Two-flop synchroniser; a request is the 1->0 step between the two flops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_s1 <= 1'b0;
                    wr_s2 <= 1'b0;
                    rd_s1 <= 1'b0;
                    rd_s2 <= 1'b0;
                end else begin
                    wr_s1 <= wrt;
                    wr_s2 <= wr_s1;
                    rd_s1 <= rd;
                    rd_s2 <= rd_s1;
                end
            end

            assign wr_req = wr_s2 & ~wr_s1;
            assign rd_req = rd_s2 & ~rd_s1;
        end else begin : g_level
            assign wr_req = wrt;
            assign rd_req = rd;
        end
    endgenerate

    assign full         = (count == depth_lvl);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_lvl);
    assign almost_empty = (count <= ae_lvl);

    // clr outranks both requests; a full FIFO still takes a write when a read frees a slot.
    assign rd_acc = ~clr & rd_req & ~empty;
    assign wr_acc = ~clr & wr_req & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + adder_width'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + adder_width'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + (adder_width+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - (adder_width+1)'(1);
            end
            if (wr_req && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_req && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (fwft) begin : g_fwft
            assign dout = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            // Holds the last word read; clr leaves it untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout <= '0;
                end else if (rd_acc) begin
                    dout <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: default, fwft and edge-mode instances checked against queue models,
// a reset-anchored vector table and hand sequences for the multi-cycle corners.
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       clr = 1'b0, wrt = 1'b0, rd = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_clr = 1'b0, f_wrt = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = '0;
    logic [7:0] f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_count;

    logic       e_clr = 1'b0, e_wrt = 1'b0, e_rd = 1'b0;
    logic [7:0] e_din = '0;
    logic [7:0] e_dout;
    logic       e_full, e_empty, e_af, e_ae, e_ovf, e_unf;
    logic [4:0] e_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_flex u_lvl (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wrt(wrt), .rd(rd), .din(din),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    fifo_flex #(.fwft(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(f_clr), .wrt(f_wrt), .rd(f_rd), .din(f_din),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_flex #(.edge_mode(1'b1)) u_edge (
        .clk(clk), .rst_n(rst_n), .clr(e_clr), .wrt(e_wrt), .rd(e_rd), .din(e_din),
        .dout(e_dout), .full(e_full), .empty(e_empty), .almost_full(e_af),
        .almost_empty(e_ae), .count(e_count), .overflow(e_ovf), .underflow(e_unf)
    );

    // Reference models: plain queues, sticky flags and last word read.
    logic [7:0] mq[$];
    bit         m_ovf, m_unf;
    logic [7:0] m_dout;
    logic [7:0] fq[$];
    bit         fm_ovf, fm_unf;

    typedef struct {
        bit         c;
        bit         w;
        bit         r;
        logic [7:0] d;
        int         exp_count;
        logic [7:0] exp_dout;
        bit         exp_ovf;
        bit         exp_unf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_main();
        chk("count", 32'(count), mq.size());
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("dout", 32'(dout), 32'(m_dout));
    endtask

    task automatic check_fwft();
        chk("f_count", 32'(f_count), fq.size());
        chk("f_empty", 32'(f_empty), 32'(fq.size() == 0));
        chk("f_full", 32'(f_full), 32'(fq.size() == 16));
        chk("f_dout", 32'(f_dout), (fq.size() != 0) ? 32'(fq[0]) : 32'h0);
        chk("f_overflow", 32'(f_ovf), 32'(fm_ovf));
        chk("f_underflow", 32'(f_unf), 32'(fm_unf));
    endtask

    task automatic step(input bit c, input bit w, input bit r, input logic [7:0] d);
        bit r_ok, w_ok;
        @(negedge clk);
        clr = c; wrt = w; rd = r; din = d;
        @(posedge clk);
        #1;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            r_ok = r && (mq.size() != 0);
            w_ok = w && (mq.size() < 16 || r_ok);
            if (r_ok) m_dout = mq.pop_front();
            if (w_ok) mq.push_back(d);
            if (w && !w_ok) m_ovf = 1'b1;
            if (r && !r_ok) m_unf = 1'b1;
        end
        check_main();
    endtask

    task automatic step_f(input bit w, input bit r, input logic [7:0] d);
        bit r_ok, w_ok;
        @(negedge clk);
        f_wrt = w; f_rd = r; f_din = d;
        @(posedge clk);
        #1;
        r_ok = r && (fq.size() != 0);
        w_ok = w && (fq.size() < 16 || r_ok);
        if (r_ok) void'(fq.pop_front());
        if (w_ok) fq.push_back(d);
        if (w && !w_ok) fm_ovf = 1'b1;
        if (r && !r_ok) fm_unf = 1'b1;
        check_fwft();
    endtask

    task automatic tick_e(input bit w, input bit r, input logic [7:0] d);
        @(negedge clk);
        e_wrt = w; e_rd = r; e_din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr = 0; wrt = 0; rd = 0; din = '0;
        f_clr = 0; f_wrt = 0; f_rd = 0; f_din = '0;
        e_clr = 0; e_wrt = 0; e_rd = 0; e_din = '0;
        mq.delete(); m_ovf = 0; m_unf = 0; m_dout = '0;
        fq.delete(); fm_ovf = 0; fm_unf = 0;
        #1;
        check_main();
        check_fwft();
        chk("e_count_rst", 32'(e_count), 32'h0);
        chk("e_dout_rst", 32'(e_dout), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {clr, wrt, rd, din, count, dout, overflow, underflow} from reset.
        vecs[0] = '{c:0, w:0, r:1, d:8'h00, exp_count:0, exp_dout:8'h00, exp_ovf:0, exp_unf:1};
        vecs[1] = '{c:0, w:1, r:0, d:8'h11, exp_count:1, exp_dout:8'h00, exp_ovf:0, exp_unf:1};
        vecs[2] = '{c:0, w:1, r:0, d:8'h22, exp_count:2, exp_dout:8'h00, exp_ovf:0, exp_unf:1};
        vecs[3] = '{c:0, w:1, r:1, d:8'h33, exp_count:2, exp_dout:8'h11, exp_ovf:0, exp_unf:1};
        vecs[4] = '{c:0, w:0, r:1, d:8'h00, exp_count:1, exp_dout:8'h22, exp_ovf:0, exp_unf:1};
        vecs[5] = '{c:1, w:1, r:0, d:8'h44, exp_count:0, exp_dout:8'h22, exp_ovf:0, exp_unf:0};
        vecs[6] = '{c:0, w:0, r:1, d:8'h00, exp_count:0, exp_dout:8'h22, exp_ovf:0, exp_unf:1};
        vecs[7] = '{c:0, w:1, r:1, d:8'h55, exp_count:1, exp_dout:8'h22, exp_ovf:0, exp_unf:1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_unf", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        // Fill 0x00..0x0F, then overflow, then simultaneous read/write at full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'(i));
            chk("fill_full", 32'(full), 32'(i == 15));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
        end
        step(0, 1, 0, 8'hEE);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(count), 32'd16);
        step(0, 0, 0, 8'h00);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 8'(8'h10 + i));
            chk("rw_full_count", 32'(count), 32'd16);
            chk("rw_full_dout", 32'(dout), 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'h00);
            chk("drain_dout", 32'(dout), (i < 12) ? 32'(i + 4) : 32'(8'h10 + i - 12));
        end
        chk("drain_empty", 32'(empty), 32'h1);

        // Mid-stream clear with a concurrent write.
        do_reset();
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'hC0 + i));
        step(1, 1, 0, 8'hEE);
        chk("clr_count", 32'(count), 32'h0);
        chk("clr_empty", 32'(empty), 32'h1);
        chk("clr_unf", 32'(underflow), 32'h0);

        // Randomised traffic: write-heavy, then read-heavy, with rare clears.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 70 : 30;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp), 8'($urandom_range(0, 255)));
        end

        // Asynchronous reset in the middle of a write.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h90 + i));
        @(negedge clk);
        wrt = 1'b1; din = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_empty", 32'(empty), 32'h1);
        chk("arst_full", 32'(full), 32'h0);
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_ae", 32'(almost_empty), 32'h1);
        chk("arst_af", 32'(almost_full), 32'h0);
        wrt = 1'b0;
        mq.delete(); m_ovf = 0; m_unf = 0; m_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 8'h5A);
        step(0, 0, 1, 8'h00);
        chk("arst_first", 32'(dout), 32'h5A);

        // First-word-fall-through instance.
        do_reset();
        step_f(1, 0, 8'hA5);
        chk("fwft_a5", 32'(f_dout), 32'hA5);
        step_f(0, 1, 8'h00);
        chk("fwft_empty", 32'(f_empty), 32'h1);
        chk("fwft_dout0", 32'(f_dout), 32'h0);
        step_f(0, 1, 8'h00);
        chk("fwft_unf", 32'(f_unf), 32'h1);
        for (int i = 0; i < 200; i++) begin
            step_f($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                   8'($urandom_range(0, 255)));
        end

        // Edge-mode instance: one write per falling edge of a long wrt pulse.
        do_reset();
        for (int i = 0; i < 5; i++) tick_e(1, 0, 8'h3C);
        chk("edge_hold_count", 32'(e_count), 32'h0);
        tick_e(0, 0, 8'h3C);
        chk("edge_k_count", 32'(e_count), 32'h0);
        tick_e(0, 0, 8'h3C);
        chk("edge_k1_count", 32'(e_count), 32'h1);
        tick_e(0, 0, 8'h00);
        tick_e(0, 0, 8'h00);
        chk("edge_once_count", 32'(e_count), 32'h1);
        tick_e(0, 1, 8'h00);
        tick_e(0, 1, 8'h00);
        tick_e(0, 0, 8'h00);
        tick_e(0, 0, 8'h00);
        chk("edge_rd_count", 32'(e_count), 32'h0);
        chk("edge_rd_dout", 32'(e_dout), 32'h3C);
        chk("edge_rd_unf", 32'(e_unf), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
